mem_access_ctrl: RTL

//  Load/store front end that sits directly upstream of the S-Machine DataMemory block.

---
 rtl/smachine_mem_pkg.sv | 20 ++
 rtl/mem_access_ctrl_if.sv | 23 ++
 rtl/sw_debounce.sv | 38 +++
 rtl/mem_access_ctrl.sv | 103 ++++++++++
 4 files changed

// File: rtl/smachine_mem_pkg.sv
// rtl/smachine_mem_pkg.sv - shared types and address map for the DataMemory front end
package smachine_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int ADDR_W_DEF   = 9;
    localparam int DATA_W_DEF   = 16;
    localparam int DB_COUNT_DEF = 50000;

    localparam int SW_ADDR0  = 4;
    localparam int SW_ADDR1  = 5;
    localparam int LED_ADDR0 = 0;
    localparam int LED_ADDR1 = 1;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - CPU load/store request bus
interface mem_access_ctrl_if #(
    parameter int ADDR_W = smachine_mem_pkg::ADDR_W_DEF,
    parameter int DATA_W = smachine_mem_pkg::DATA_W_DEF
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_busy;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata, cpu_busy
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata, cpu_busy
    );
endinterface

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - two-flop synchroniser plus stability counter for one board switch
module sw_debounce #(
    parameter int DB_COUNT = smachine_mem_pkg::DB_COUNT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sw_raw,
    output logic sw_clean
);
    localparam int              CNT_W   = (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_COUNT - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_clean;

    // Any sample agreeing with the current clean level restarts the stability window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_clean <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], sw_raw};
            if (r_sync[1] == r_clean) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_clean <= r_sync[1];
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign sw_clean = r_clean;

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-word load/store sequencer in front of DataMemory
module mem_access_ctrl
    import smachine_mem_pkg::state_t, smachine_mem_pkg::IDLE, smachine_mem_pkg::SETUP,
           smachine_mem_pkg::ACCESS, smachine_mem_pkg::RESP;
#(
    parameter int ADDR_W   = smachine_mem_pkg::ADDR_W_DEF,
    parameter int DATA_W   = smachine_mem_pkg::DATA_W_DEF,
    parameter int DB_COUNT = smachine_mem_pkg::DB_COUNT_DEF,
    parameter int SW_ADDR0 = smachine_mem_pkg::SW_ADDR0,
    parameter int SW_ADDR1 = smachine_mem_pkg::SW_ADDR1
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_access_ctrl_if.slave  cpu,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read_write,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    input  logic [1:0]        sw_raw,
    output logic [1:0]        sw_clean
);
    state_t            r_state;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_ack;
    logic              r_busy;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_rw;
    logic [DATA_W-1:0] r_mem_data_in;
    logic              w_sw_hit;

    assign w_sw_hit = (r_addr == ADDR_W'(SW_ADDR0)) || (r_addr == ADDR_W'(SW_ADDR1));

    // Outputs are registered from the current state, so each one shows up a cycle after it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_ack         <= 1'b0;
            r_busy        <= 1'b0;
            r_rdata       <= '0;
            r_mem_addr    <= '0;
            r_mem_rw      <= 1'b0;
            r_mem_data_in <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= 1'b0;
                    if (cpu.cpu_req) begin
                        r_we    <= cpu.cpu_we;
                        r_addr  <= cpu.cpu_addr;
                        r_wdata <= cpu.cpu_wdata;
                        r_busy  <= 1'b1;
                        r_state <= SETUP;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                SETUP: begin
                    r_mem_addr    <= r_addr;
                    r_mem_data_in <= r_wdata;
                    r_mem_rw      <= 1'b0;
                    r_state       <= ACCESS;
                end
                ACCESS: begin
                    // Switch addresses are read-only: the store is acked but never strobed.
                    r_mem_rw <= r_we && !w_sw_hit;
                    r_state  <= RESP;
                end
                RESP: begin
                    r_mem_rw <= 1'b0;
                    r_ack    <= 1'b1;
                    if (!r_we) begin
                        r_rdata <= mem_data_out;
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cpu.cpu_ack   = r_ack;
    assign cpu.cpu_busy  = r_busy;
    assign cpu.cpu_rdata = r_rdata;
    assign mem_addr      = r_mem_addr;
    assign mem_read_write = r_mem_rw;
    assign mem_data_in   = r_mem_data_in;

    for (genvar i = 0; i < 2; i++) begin : g_db
        sw_debounce #(.DB_COUNT(DB_COUNT)) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .sw_raw   (sw_raw[i]),
            .sw_clean (sw_clean[i])
        );
    end

endmodule
